// File: rtl/pspin_ctrl_seq_master.sv
// pspin_ctrl_seq_master
//   AXI-Lite initiator that boots the PsPIN control register block and then
//   forwards the cluster stdout FIFO to an AXI-Stream port until every enabled
//   cluster has reported end-of-computation and the FIFO is empty.
//
//   Boot sequence: 0x0004 <= 0 (release cluster reset), 0x0000 <= fetch mask,
//   then poll 0x1000 (stdout FIFO, 32'hFFFFFFFF = empty) and 0x0100 (EOC bits).
//
// Ports
//   clk, rst            clock, asynchronous active-high reset
//   start, fetch_mask   run request (ignored while busy) and cluster enable mask
//   m_axil_*            AXI-Lite master channels AW/W/B/AR/R
//   m_axis_t*           stdout word stream (tdata/tvalid out, tready in)
//   busy, done, error   run in progress, 1-cycle completion pulse, sticky error
module pspin_ctrl_seq_master #(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STRB_WIDTH    = DATA_WIDTH / 8,
  parameter int NUM_CLUSTERS  = 2,
  parameter int POLL_INTERVAL = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [NUM_CLUSTERS-1:0] fetch_mask,
  output logic [ADDR_WIDTH-1:0]   m_axil_awaddr,
  output logic [2:0]              m_axil_awprot,
  output logic                    m_axil_awvalid,
  input  logic                    m_axil_awready,
  output logic [DATA_WIDTH-1:0]   m_axil_wdata,
  output logic [STRB_WIDTH-1:0]   m_axil_wstrb,
  output logic                    m_axil_wvalid,
  input  logic                    m_axil_wready,
  input  logic [1:0]              m_axil_bresp,
  input  logic                    m_axil_bvalid,
  output logic                    m_axil_bready,
  output logic [ADDR_WIDTH-1:0]   m_axil_araddr,
  output logic [2:0]              m_axil_arprot,
  output logic                    m_axil_arvalid,
  input  logic                    m_axil_arready,
  input  logic [DATA_WIDTH-1:0]   m_axil_rdata,
  input  logic [1:0]              m_axil_rresp,
  input  logic                    m_axil_rvalid,
  output logic                    m_axil_rready,
  output logic [31:0]             m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic                    error
);

  localparam int CNT_W = $clog2(POLL_INTERVAL + 1);

  localparam logic [ADDR_WIDTH-1:0] ADDR_FETCH = ADDR_WIDTH'(16'h0000);
  localparam logic [ADDR_WIDTH-1:0] ADDR_RST   = ADDR_WIDTH'(16'h0004);
  localparam logic [ADDR_WIDTH-1:0] ADDR_EOC   = ADDR_WIDTH'(16'h0100);
  localparam logic [ADDR_WIDTH-1:0] ADDR_FIFO  = ADDR_WIDTH'(16'h1000);

  typedef enum logic [3:0] {
    S_IDLE, S_WR_RST, S_WR_FETCH, S_RD_FIFO, S_PUSH, S_RD_EOC, S_WAIT, S_DONE, S_ERR
  } state_t;

  state_t                  state_q;
  logic [NUM_CLUSTERS-1:0] mask_q;
  logic                    eoc_seen_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [ADDR_WIDTH-1:0]   awaddr_q, araddr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
  logic [31:0]             tdata_q;
  logic                    tvalid_q, busy_q, done_q, error_q;

  logic aw_ok, w_ok, rd_ok, eoc_all;

  // A channel counts as accepted once its valid has dropped or is being taken now.
  assign aw_ok   = !awvalid_q || m_axil_awready;
  assign w_ok    = !wvalid_q || m_axil_wready;
  assign rd_ok   = (m_axil_rresp == 2'b00);
  assign eoc_all = ((m_axil_rdata[NUM_CLUSTERS-1:0] & mask_q) == mask_q);

  // NOTE: every register below is updated with <= so all state advances from the
  // same pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mask_q     <= '0;
      eoc_seen_q <= 1'b0;
      cnt_q      <= '0;
      awaddr_q   <= '0;
      araddr_q   <= '0;
      wdata_q    <= '0;
      awvalid_q  <= 1'b0;
      wvalid_q   <= 1'b0;
      bready_q   <= 1'b0;
      arvalid_q  <= 1'b0;
      rready_q   <= 1'b0;
      tdata_q    <= '0;
      tvalid_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q    <= S_WR_RST;
            mask_q     <= fetch_mask;
            eoc_seen_q <= 1'b0;
            error_q    <= 1'b0;
            busy_q     <= 1'b1;
            awaddr_q   <= ADDR_RST;
            wdata_q    <= '0;
            awvalid_q  <= 1'b1;
            wvalid_q   <= 1'b1;
          end
        end

        S_WR_RST, S_WR_FETCH: begin
          if (awvalid_q && m_axil_awready) awvalid_q <= 1'b0;
          if (wvalid_q && m_axil_wready)   wvalid_q  <= 1'b0;
          if (!bready_q && aw_ok && w_ok)  bready_q  <= 1'b1;
          if (bready_q && m_axil_bvalid) begin
            bready_q <= 1'b0;
            if (m_axil_bresp != 2'b00) begin
              state_q <= S_ERR;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (state_q == S_WR_RST) begin
              state_q   <= S_WR_FETCH;
              awaddr_q  <= ADDR_FETCH;
              wdata_q   <= DATA_WIDTH'(mask_q);
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
            end else begin
              state_q   <= S_RD_FIFO;
              araddr_q  <= ADDR_FIFO;
              arvalid_q <= 1'b1;
            end
          end
        end

        S_RD_FIFO, S_RD_EOC: begin
          if (arvalid_q && m_axil_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
          end
          if (rready_q && m_axil_rvalid) begin
            rready_q <= 1'b0;
            if (!rd_ok) begin
              state_q <= S_ERR;
              error_q <= 1'b1;
              busy_q  <= 1'b0;
            end else if (state_q == S_RD_FIFO) begin
              if (m_axil_rdata != '1) begin
                state_q  <= S_PUSH;
                tdata_q  <= m_axil_rdata[31:0];
                tvalid_q <= 1'b1;
              end else if (eoc_seen_q) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
                busy_q  <= 1'b0;
              end else begin
                state_q   <= S_RD_EOC;
                araddr_q  <= ADDR_EOC;
                arvalid_q <= 1'b1;
              end
            end else begin
              // EOC poll: once all enabled clusters finished, drain the FIFO one last time.
              eoc_seen_q <= eoc_all;
              if (eoc_all) begin
                state_q   <= S_RD_FIFO;
                araddr_q  <= ADDR_FIFO;
                arvalid_q <= 1'b1;
              end else begin
                state_q <= S_WAIT;
                cnt_q   <= '0;
              end
            end
          end
        end

        S_PUSH: begin
          if (m_axis_tready) begin
            tvalid_q  <= 1'b0;
            state_q   <= S_RD_FIFO;
            araddr_q  <= ADDR_FIFO;
            arvalid_q <= 1'b1;
          end
        end

        S_WAIT: begin
          if (cnt_q == CNT_W'(POLL_INTERVAL - 1)) begin
            cnt_q     <= '0;
            state_q   <= S_RD_FIFO;
            araddr_q  <= ADDR_FIFO;
            arvalid_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        S_ERR: state_q <= S_IDLE;

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign m_axil_awaddr  = awaddr_q;
  assign m_axil_awprot  = 3'b000;
  assign m_axil_awvalid = awvalid_q;
  assign m_axil_wdata   = wdata_q;
  assign m_axil_wstrb   = '1;
  assign m_axil_wvalid  = wvalid_q;
  assign m_axil_bready  = bready_q;
  assign m_axil_araddr  = araddr_q;
  assign m_axil_arprot  = 3'b000;
  assign m_axil_arvalid = arvalid_q;
  assign m_axil_rready  = rready_q;
  assign m_axis_tdata   = tdata_q;
  assign m_axis_tvalid  = tvalid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign error          = error_q;

endmodule

// File: tb/tb_pspin_ctrl_seq_master.sv
// tb_pspin_ctrl_seq_master
//   Randomised bench: a scenario generator derives the expected AXI-Lite
//   transaction list and stream words from the boot/poll rules and loads the
//   register-slave stub with matching responses; a monitor process compares
//   every handshake against the expected queues.
module tb_pspin_ctrl_seq_master;

  localparam int P = 8;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [1:0]  fetch_mask;
  logic [31:0] awaddr, wdata, araddr, rdata, tdata;
  logic [2:0]  awprot, arprot;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready, tvalid, tready;
  logic [1:0]  bresp, rresp;
  logic        busy, done, error;

  pspin_ctrl_seq_master #(.NUM_CLUSTERS(2), .POLL_INTERVAL(P)) dut (
    .clk(clk), .rst(rst), .start(start), .fetch_mask(fetch_mask),
    .m_axil_awaddr(awaddr), .m_axil_awprot(awprot), .m_axil_awvalid(awvalid),
    .m_axil_awready(awready), .m_axil_wdata(wdata), .m_axil_wstrb(wstrb),
    .m_axil_wvalid(wvalid), .m_axil_wready(wready), .m_axil_bresp(bresp),
    .m_axil_bvalid(bvalid), .m_axil_bready(bready), .m_axil_araddr(araddr),
    .m_axil_arprot(arprot), .m_axil_arvalid(arvalid), .m_axil_arready(arready),
    .m_axil_rdata(rdata), .m_axil_rresp(rresp), .m_axil_rvalid(rvalid),
    .m_axil_rready(rready), .m_axis_tdata(tdata), .m_axis_tvalid(tvalid),
    .m_axis_tready(tready), .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  int cycle = 0;
  always @(posedge clk) cycle <= cycle + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    int          gap;   // cycles from previous R handshake to this arvalid rise, 0 = unchecked
  } txn_t;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rsp_t;

  txn_t        exp_q[$];
  logic [31:0] exp_stream[$];
  logic [1:0]  wr_resp_q[$];
  logic [31:0] fifo_q[$];
  rsp_t        eoc_q[$];
  int          ready_pct  = 100;
  int          tready_pct = 100;
  int          done_cnt   = 0;

  function automatic bit roll(input int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  // Register-slave stub: serves the scripted responses with random ready/valid timing.
  initial begin
    bit          aw_got, w_got, ar_got, b_fire, r_fire;
    logic [31:0] ar_data;
    logic [1:0]  ar_resp;
    rsp_t        e;
    aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0; tready = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_got = 0; w_got = 0; ar_got = 0; b_fire = 0; r_fire = 0;
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0; tready = 0;
        continue;
      end
      if (b_fire) begin bvalid = 0; bresp = 0; b_fire = 0; aw_got = 0; w_got = 0; end
      if (r_fire) begin rvalid = 0; rresp = 0; r_fire = 0; ar_got = 0; end
      awready = 0; wready = 0; arready = 0;
      if (aw_got && w_got && !bvalid && roll(ready_pct)) begin
        bvalid = 1;
        bresp  = (wr_resp_q.size() != 0) ? wr_resp_q.pop_front() : 2'b00;
      end
      if (ar_got && !rvalid && roll(ready_pct)) begin
        rvalid = 1; rdata = ar_data; rresp = ar_resp;
      end
      if (awvalid && !aw_got && roll(ready_pct)) begin awready = 1; aw_got = 1; end
      if (wvalid && !w_got && roll(ready_pct))   begin wready = 1; w_got = 1; end
      if (arvalid && !ar_got && roll(ready_pct)) begin
        arready = 1; ar_got = 1; ar_data = 32'h0; ar_resp = 2'b00;
        if (araddr == 32'h1000) begin
          ar_data = (fifo_q.size() != 0) ? fifo_q.pop_front() : 32'hFFFF_FFFF;
        end else if (araddr == 32'h0100 && eoc_q.size() != 0) begin
          e = eoc_q.pop_front();
          ar_data = e.data; ar_resp = e.resp;
        end
      end
      if (bvalid && bready) b_fire = 1;
      if (rvalid && rready) r_fire = 1;
      tready = roll(tready_pct);
    end
  end

  // Monitor: handshakes complete at the next rising edge, so sampling here sees them.
  initial begin
    logic [31:0] cap_aw, cap_w, prev_tdata;
    bit          prev_stall, prev_ar, prev_done;
    int          ar_rise, last_r;
    txn_t        t;
    cap_aw = 0; cap_w = 0; prev_tdata = 0;
    prev_stall = 0; prev_ar = 0; prev_done = 0; ar_rise = 0; last_r = 0;
    forever begin
      @(negedge clk);
      #1;
      if (rst) begin
        prev_stall = 0; prev_ar = 0; prev_done = 0;
        continue;
      end
      if (bready) check("bready_before_aw_w_accepted", {30'b0, awvalid, wvalid}, 32'h0);
      if (awvalid && awready) begin
        cap_aw = awaddr;
        check("awprot", 32'(awprot), 32'h0);
      end
      if (wvalid && wready) begin
        cap_w = wdata;
        check("wstrb", 32'(wstrb), 32'hF);
      end
      if (arvalid && !prev_ar) ar_rise = cycle;
      prev_ar = arvalid;
      if (bvalid && bready) begin
        check("write_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          t = exp_q.pop_front();
          check("txn_kind_write", 32'(t.is_wr), 32'h1);
          check("write_addr", cap_aw, t.addr);
          check("write_data", cap_w, t.data);
        end
      end
      if (arvalid && arready) begin
        check("arprot", 32'(arprot), 32'h0);
        check("read_expected", 32'(exp_q.size() != 0), 32'h1);
        if (exp_q.size() != 0) begin
          t = exp_q.pop_front();
          check("txn_kind_read", 32'(t.is_wr), 32'h0);
          check("read_addr", araddr, t.addr);
          if (t.gap != 0) check("poll_gap_cycles", 32'(ar_rise - last_r), 32'(t.gap));
        end
      end
      if (rvalid && rready) last_r = cycle;
      if (prev_stall) begin
        check("tvalid_held", 32'(tvalid), 32'h1);
        check("tdata_held", tdata, prev_tdata);
      end
      if (tvalid) check("no_ar_while_push", 32'(arvalid), 32'h0);
      if (tvalid && tready) begin
        check("stream_expected", 32'(exp_stream.size() != 0), 32'h1);
        if (exp_stream.size() != 0) check("stream_word", tdata, exp_stream.pop_front());
      end
      prev_stall = tvalid && !tready;
      prev_tdata = tdata;
      if (done) begin
        check("done_single_cycle", 32'(prev_done), 32'h0);
        check("done_txns_left", 32'(exp_q.size()), 32'h0);
        check("done_words_left", 32'(exp_stream.size()), 32'h0);
        done_cnt++;
      end
      prev_done = done;
    end
  end

  function automatic txn_t mk(input bit w, input logic [31:0] a, input logic [31:0] d, input int g);
    txn_t t;
    t.is_wr = w; t.addr = a; t.data = d; t.gap = g;
    return t;
  endfunction

  // Reference model. err_kind: 0 none, 1 SLVERR on the fetch-enable write,
  // 2 SLVERR on the first EOC poll. n_unsat: EOC polls that report unfinished clusters.
  task automatic build_case(input logic [1:0] mask, input int err_kind, input int n_unsat,
                            output bit exp_err);
    bit          eoc_seen;
    int          gap, polls, nw;
    logic [31:0] w, e;
    logic [1:0]  r, resp;
    exp_q.delete(); exp_stream.delete(); wr_resp_q.delete(); fifo_q.delete(); eoc_q.delete();
    exp_err = 0;
    exp_q.push_back(mk(1, 32'h4, 32'h0, 0));
    exp_q.push_back(mk(1, 32'h0, {30'b0, mask}, 0));
    wr_resp_q.push_back(2'b00);
    wr_resp_q.push_back(err_kind == 1 ? 2'b10 : 2'b00);
    if (err_kind == 1) begin exp_err = 1; return; end
    eoc_seen = 0; gap = 0; polls = 0;
    while (polls < 8) begin
      nw = $urandom_range(0, 2);
      for (int i = 0; i < nw; i++) begin
        w = $urandom;
        if (w == 32'hFFFF_FFFF) w = 32'h1234_5678;
        exp_q.push_back(mk(0, 32'h1000, 0, gap)); gap = 0;
        fifo_q.push_back(w);
        exp_stream.push_back(w);
      end
      exp_q.push_back(mk(0, 32'h1000, 0, gap)); gap = 0;
      fifo_q.push_back(32'hFFFF_FFFF);
      if (eoc_seen) break;
      e = $urandom;
      if (polls < n_unsat && mask != 2'b00) begin
        do r = 2'($urandom_range(0, 3)); while ((r & mask) == mask);
        e[1:0] = r;
      end else begin
        e[1:0] = e[1:0] | mask;
      end
      resp = (err_kind == 2) ? 2'b10 : 2'b00;
      exp_q.push_back(mk(0, 32'h0100, 0, 0));
      eoc_q.push_back('{data: e, resp: resp});
      if (resp != 2'b00) begin exp_err = 1; return; end
      eoc_seen = ((e[1:0] & mask) == mask);
      gap = eoc_seen ? 1 : P + 1;
      polls++;
    end
  endtask

  task automatic do_start(input logic [1:0] mask);
    @(negedge clk); #2;
    start = 1; fetch_mask = mask;
    @(negedge clk); #2;
    start = 0;
    check("start_awvalid_latency", 32'(awvalid), 32'h1);
    check("start_awaddr", awaddr, 32'h4);
    check("start_busy", 32'(busy), 32'h1);
    check("start_clears_error", 32'(error), 32'h0);
  endtask

  task automatic run_case(input logic [1:0] mask, input int err_kind, input int n_unsat,
                          input int rpct, input int tpct, input bit poke_busy, input bit poke_done);
    bit exp_err;
    int d0, k;
    ready_pct = rpct; tready_pct = tpct;
    build_case(mask, err_kind, n_unsat, exp_err);
    d0 = done_cnt;
    do_start(mask);
    for (k = 0; k < 4000; k++) begin
      @(negedge clk); #2;
      start = 0;
      if (!busy) break;
      if (poke_busy && k == 5) begin start = 1; fetch_mask = ~mask; end
    end
    start = 0;
    if (k == 4000) check("run_timeout_busy", 32'(busy), 32'h0);
    check("done_pulses", 32'(done_cnt - d0), exp_err ? 32'h0 : 32'h1);
    check("error_flag", 32'(error), 32'(exp_err));
    check("txns_left", 32'(exp_q.size()), 32'h0);
    check("words_left", 32'(exp_stream.size()), 32'h0);
    if (poke_done && !exp_err) begin
      check("done_visible", 32'(done), 32'h1);
      start = 1; fetch_mask = mask;
      @(negedge clk); #2;
      start = 0;
      check("start_in_done_ignored", {30'b0, busy, awvalid}, 32'h0);
      @(negedge clk); #2;
      check("still_idle", {30'b0, busy, awvalid}, 32'h0);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bit dummy;
    int k;
    rst = 1; start = 0; fetch_mask = 2'b00;
    repeat (3) @(negedge clk);
    #2;
    check("reset_outputs", {23'b0, awvalid, wvalid, bready, arvalid, rready, tvalid, busy, done, error}, 32'h0);
    rst = 0;
    @(negedge clk); #2;
    check("idle_after_reset", {29'b0, busy, awvalid, arvalid}, 32'h0);

    run_case(2'b11, 0, 0, 100, 100, 0, 0);
    run_case(2'b11, 0, 2, 100, 100, 0, 1);
    run_case(2'b11, 2, 0, 60, 100, 0, 0);
    check("error_sticky_idle", 32'(error), 32'h1);
    run_case(2'b01, 1, 0, 40, 100, 0, 0);
    run_case(2'b00, 0, 0, 50, 50, 0, 0);

    // Reset while the fetch-enable write is in flight.
    ready_pct = 30; tready_pct = 100;
    build_case(2'b11, 0, 0, dummy);
    do_start(2'b11);
    for (k = 0; k < 200; k++) begin
      @(negedge clk); #2;
      if (awvalid && awaddr == 32'h0) break;
    end
    check("reached_wr_fetch", 32'(k < 200), 32'h1);
    rst = 1;
    @(negedge clk); #2;
    check("reset_mid_write", {23'b0, awvalid, wvalid, bready, arvalid, rready, tvalid, busy, done, error}, 32'h0);
    rst = 0;
    run_case(2'b10, 0, 1, 70, 70, 0, 0);

    for (int i = 0; i < 12; i++) begin
      run_case(2'($urandom_range(0, 3)), 0, $urandom_range(0, 2),
               $urandom_range(20, 100), $urandom_range(20, 100), 1, i % 3 == 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
